// File: rtl/mmio_fifo_mac.sv
// Multiply-accumulate stage behind the MMIO write FIFO: LEN signed 32x32 products per batch,
// result held until acknowledged. Optional saturating accumulation via `define MAC_SAT_EN.
module mmio_fifo_mac #(
  parameter int unsigned LEN   = 8,
  parameter int unsigned CNT_W = $clog2(LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [63:0]      in_data,
  output logic             in_ready,
  output logic             res_valid,
  output logic [63:0]      res_data,
  input  logic             res_ack,
  output logic [CNT_W-1:0] count,
  output logic             res_ovf
);

  typedef enum logic [1:0] {RUN, FLUSH, DONE} state_t;

  state_t      state;
  logic [63:0] acc;
  logic [63:0] p;
  logic        p_vld;
  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] acc_nxt;
  logic        accept;
  logic        ack;

  assign accept   = in_valid && in_ready;
  // Ack only counts once the result has actually been presented.
  assign ack      = res_ack && (state == DONE) && res_valid;
  assign res_data = acc;

  // Low 64 bits of the sign-extended product are the exact signed 32x32 product.
  assign ext_a = {{32{in_data[63]}}, in_data[63:32]};
  assign ext_b = {{32{in_data[31]}}, in_data[31:0]};

`ifdef MAC_SAT_EN
  logic [63:0] sum;
  logic        sat;

  always_comb begin
    sum = acc + p;
    sat = (acc[63] == p[63]) && (sum[63] != acc[63]);
    if (sat) begin
      acc_nxt = acc[63] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
    end else begin
      acc_nxt = sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_ovf <= 1'b0;
    end else if (clr || ack) begin
      res_ovf <= 1'b0;
    end else if (p_vld && sat) begin
      res_ovf <= 1'b1;
    end
  end
`else
  assign acc_nxt = acc + p;
  assign res_ovf = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      acc       <= '0;
      p         <= '0;
      p_vld     <= 1'b0;
      count     <= '0;
      res_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else if (clr) begin
      state     <= RUN;
      acc       <= '0;
      p_vld     <= 1'b0;
      count     <= '0;
      res_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      p_vld <= accept;
      if (accept) begin
        p <= ext_a * ext_b;
      end
      if (p_vld) begin
        acc <= acc_nxt;
      end
      case (state)
        RUN: begin
          if (accept) begin
            count <= count + CNT_W'(1);
            if (count == CNT_W'(LEN - 1)) begin
              state    <= FLUSH;
              in_ready <= 1'b0;
            end
          end
        end
        FLUSH: begin
          state <= DONE;
        end
        DONE: begin
          if (ack) begin
            state     <= RUN;
            acc       <= '0;
            count     <= '0;
            res_valid <= 1'b0;
            in_ready  <= 1'b1;
          end else begin
            res_valid <= 1'b1;
          end
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_fifo_mac.sv
// Scoreboard bench for mmio_fifo_mac; expected batch results come from a wide-arithmetic model.
module tb_mmio_fifo_mac;

  localparam int unsigned LEN   = 8;
  localparam int unsigned CNT_W = $clog2(LEN + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clr = 1'b0;
  logic             in_valid = 1'b0;
  logic [63:0]      in_data = '0;
  logic             in_ready;
  logic             res_valid;
  logic [63:0]      res_data;
  logic             res_ack = 1'b0;
  logic [CNT_W-1:0] count;
  logic             res_ovf;

  mmio_fifo_mac #(.LEN(LEN), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .res_valid(res_valid), .res_data(res_data), .res_ack(res_ack),
    .count(count), .res_ovf(res_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic        ovf;
  } res_t;

  res_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] m_acc;
  logic        m_ovf;
  logic [31:0] av[LEN];
  logic [31:0] bv[LEN];

  // Reference: exact signed product, 65-bit sum, overflow when the two top bits disagree.
  function automatic void model_add(input logic [31:0] a, input logic [31:0] b);
    longint      prod;
    logic [64:0] w;
    prod = longint'($signed(a)) * longint'($signed(b));
    w    = {m_acc[63], m_acc} + {prod[63], prod};
`ifdef MAC_SAT_EN
    if (w[64] != w[63]) begin
      m_acc = w[64] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
      m_ovf = 1'b1;
    end else begin
      m_acc = w[63:0];
    end
`else
    m_acc = w[63:0];
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives av/bv as one batch; returns with the time 1 unit after the edge accepting the last word.
  task automatic feed_batch(input int bubbles);
    res_t r;
    m_acc = '0;
    m_ovf = 1'b0;
    for (int i = 0; i < int'(LEN); i++) begin
      if (bubbles > 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, bubbles)) tick();
      end
      in_valid = 1'b1;
      in_data  = {av[i], bv[i]};
      n_cmp++;
      if (in_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL feed_ready word %0d: in_ready=%b required 1", i, in_ready);
      end
      model_add(av[i], bv[i]);
      tick();
    end
    in_valid = 1'b0;
    r.data = m_acc;
    r.ovf  = m_ovf;
    sb.push_back(r);
    n_cmp++;
    if (in_ready !== 1'b0 || count !== CNT_W'(LEN)) begin
      n_bad++;
      $display("FAIL batch_full: in_ready=%b count=%0d required 0 and %0d", in_ready, count, LEN);
    end
  endtask

  task automatic collect(output bit got, output int lat);
    lat = 0;
    while (res_valid !== 1'b1 && lat < 10) begin
      tick();
      lat++;
    end
    got = (res_valid === 1'b1);
  endtask

  task automatic do_ack();
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if ({in_ready, res_valid, res_ovf} !== 3'b100 || count !== '0 || res_data !== '0) begin
      n_bad++;
      $display("FAIL reset: rdy=%b vld=%b ovf=%b cnt=%0d data=%h required 1 0 0 0 0",
               in_ready, res_valid, res_ovf, count, res_data);
    end
  endtask

  task automatic test_basic();
    bit   got;
    int   lat;
    res_t e;
    for (int i = 0; i < int'(LEN); i++) begin
      av[i] = 32'(i + 1);
      bv[i] = 32'd2;
    end
    feed_batch(0);
    collect(got, lat);
    e = sb.pop_front();
    n_cmp++;
    if (!got || lat != 2) begin
      n_bad++;
      $display("FAIL basic_latency: got=%0d lat=%0d required 1 and 2", got, lat);
    end
    n_cmp++;
    if (res_data !== e.data || res_data !== 64'h48 || count !== CNT_W'(LEN)) begin
      n_bad++;
      $display("FAIL basic_data: data=%h count=%0d required %h and %0d", res_data, count, e.data, LEN);
    end
    do_ack();
    n_cmp++;
    if (res_valid !== 1'b0 || count !== '0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_ack: vld=%b cnt=%0d rdy=%b required 0 0 1", res_valid, count, in_ready);
    end
  endtask

  task automatic test_negative();
    bit   got;
    int   lat;
    res_t e;
    for (int i = 0; i < int'(LEN); i++) begin
      av[i] = 32'hFFFF_FFFD;
      bv[i] = 32'd5;
    end
    // A stray ack while accumulating must have no effect.
    res_ack = 1'b1;
    feed_batch(0);
    res_ack = 1'b0;
    collect(got, lat);
    e = sb.pop_front();
    n_cmp++;
    if (!got || res_data !== e.data || res_data !== 64'hFFFF_FFFF_FFFF_FF88) begin
      n_bad++;
      $display("FAIL negative_data: got=%0d data=%h required %h", got, res_data, e.data);
    end
    do_ack();
    n_cmp++;
    if (res_valid !== 1'b0 || count !== '0) begin
      n_bad++;
      $display("FAIL negative_ack: vld=%b cnt=%0d required 0 0", res_valid, count);
    end
  endtask

  task automatic test_overrun();
    bit   got;
    int   lat;
    res_t e;
    for (int i = 0; i < int'(LEN); i++) begin
      av[i] = 32'(i * 3 + 1);
      bv[i] = 32'd3;
    end
    feed_batch(0);
    in_valid = 1'b1;
    in_data  = {32'd9, 32'd9};
    collect(got, lat);
    e = sb.pop_front();
    repeat (3) tick();
    n_cmp++;
    if (!got || res_data !== e.data || count !== CNT_W'(LEN) || in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL overrun_hold: got=%0d data=%h cnt=%0d rdy=%b required %h %0d 0",
               got, res_data, count, in_ready, e.data, LEN);
    end
    in_data = {32'd5, 32'd7};
    do_ack();
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (count !== CNT_W'(1) || res_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL overrun_restart: cnt=%0d vld=%b required 1 0", count, res_valid);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_cmp++;
    if (count !== '0 || res_data !== '0) begin
      n_bad++;
      $display("FAIL overrun_clr: cnt=%0d data=%h required 0 0", count, res_data);
    end
  endtask

  task automatic test_clr();
    bit   got;
    int   lat;
    res_t e;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = {32'd4, 32'd4};
      tick();
    end
    n_cmp++;
    if (count !== CNT_W'(3)) begin
      n_bad++;
      $display("FAIL clr_pre: cnt=%0d required 3", count);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    in_valid = 1'b0;
    n_cmp++;
    if (count !== '0 || res_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL clr_state: cnt=%0d vld=%b rdy=%b required 0 0 1", count, res_valid, in_ready);
    end
    for (int i = 0; i < int'(LEN); i++) begin
      av[i] = 32'd1;
      bv[i] = 32'd1;
    end
    feed_batch(0);
    collect(got, lat);
    e = sb.pop_front();
    n_cmp++;
    if (!got || res_data !== e.data || res_data !== 64'd8) begin
      n_bad++;
      $display("FAIL clr_batch: got=%0d data=%h required %h", got, res_data, e.data);
    end
    do_ack();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = {32'd6, 32'd7};
      tick();
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (count !== '0 || res_data !== '0 || res_valid !== 1'b0 || res_ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: cnt=%0d data=%h vld=%b ovf=%b required all 0",
               count, res_data, res_valid, res_ovf);
    end
    #2 rst_n = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || count !== '0 || res_data !== '0) begin
      n_bad++;
      $display("FAIL async_release: rdy=%b cnt=%0d data=%h required 1 0 0", in_ready, count, res_data);
    end
    tick();
  endtask

  task automatic test_overflow();
    bit   got;
    int   lat;
    res_t e;
    for (int i = 0; i < int'(LEN); i++) begin
      av[i] = 32'h7FFF_FFFF;
      bv[i] = 32'h7FFF_FFFF;
    end
    feed_batch(0);
    collect(got, lat);
    e = sb.pop_front();
    repeat (2) tick();
    n_cmp++;
    if (!got || res_data !== e.data || res_ovf !== e.ovf) begin
      n_bad++;
      $display("FAIL ovf_model: got=%0d data=%h ovf=%b required %h %b", got, res_data, res_ovf, e.data, e.ovf);
    end
`ifdef MAC_SAT_EN
    n_cmp++;
    if (res_data !== 64'h7FFF_FFFF_FFFF_FFFF || res_ovf !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_sat: data=%h ovf=%b required 7fffffffffffffff 1", res_data, res_ovf);
    end
`else
    n_cmp++;
    if (res_data !== 64'hFFFF_FFF8_0000_0008 || res_ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL ovf_wrap: data=%h ovf=%b required fffffff800000008 0", res_data, res_ovf);
    end
`endif
    do_ack();
    n_cmp++;
    if (res_ovf !== 1'b0 || res_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL ovf_ack: ovf=%b vld=%b required 0 0", res_ovf, res_valid);
    end
  endtask

  task automatic test_back_to_back();
    bit   got;
    int   lat;
    res_t e;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < int'(LEN); i++) begin
        av[i] = $urandom();
        bv[i] = $urandom();
      end
      feed_batch(k == 0 ? 0 : 2);
      collect(got, lat);
      e = sb.pop_front();
      n_cmp++;
      if (!got || lat != 2 || res_data !== e.data || res_ovf !== e.ovf) begin
        n_bad++;
        $display("FAIL b2b_batch%0d: got=%0d lat=%0d data=%h ovf=%b required lat 2 %h %b",
                 k, got, lat, res_data, res_ovf, e.data, e.ovf);
      end
      do_ack();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_overrun();
    test_clr();
    test_async_reset();
    test_overflow();
    test_back_to_back();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
